regfile_mp_sb: RTL
==================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port register file with a per-register busy scoreboard and hardware clear-on-reset.
//  Sits in the decode stage. Operand reads are asynchronous; writeback and issue-marking are synchronous.
//  Optional write-to-read bypass. Successor to the single-write, dual-read decode register file.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREGS     32  number of registers (power of 2, >=4); AW = $clog2(NREGS)
//  NRD       2   number of read ports
//  NWR       2   number of write ports; higher index has priority
//  BYPASS    1   1: same-cycle write data forwarded to reads; 0: reads see array only
//  ZERO_REG  1   1: register 0 reads 0, ignores writes and is never busy
// PORTS
//  clk        in   1         clock, all state on rising edge
//  reset      in   1         synchronous, active-high
//  ready      out  1         1 = clear sequence finished, file usable
//  we         in   NWR       write enables, one bit per port
//  wb_addr    in   NWR*AW    write addresses, port i at [i*AW +: AW]
//  wb_data    in   NWR*XLEN  write data, port i at [i*XLEN +: XLEN]
//  rs_addr    in   NRD*AW    read addresses, port j at [j*AW +: AW]
//  rs_data    out  NRD*XLEN  read data (combinational)
//  rs_busy    out  NRD       1 = register has an outstanding producer
//  set_busy   in   1         issue: mark set_addr busy
//  set_addr   in   AW        register being claimed by an issued instruction
// BEHAVIOUR
//  - Reset: on any edge with reset=1, state<=CLEAR and clr_idx<=0. ready=0.
//    The array is not written while reset is held.
//  - Reset mid-clear or mid-operation restarts the clear from index 0.
//  - CLEAR state, reset=0: each edge writes 0 to regs[clr_idx], clears busy[clr_idx] and increments clr_idx.
//    The edge that clears index NREGS-1 moves the block to READY, so ready=1 exactly NREGS edges after reset deasserts.
//  - During CLEAR: we and set_busy are ignored. rs_data=0 and rs_busy=0 on all ports.
//  - READY state: stays in READY until reset. There is no other transition.
//  - Write (READY only): port i with we[i]=1 writes wb_data_i to regs[wb_addr_i] and clears busy[wb_addr_i].
//    If several ports target the same address, the highest-index enabled port's data wins.
//  - ZERO_REG=1: writes and set_busy to address 0 are dropped. Address 0 always reads 0 with busy=0.
//  - Scoreboard: set_busy=1 sets busy[set_addr].
//    If set_busy and a write target the same register in the same cycle, busy ends at 1 (the new producer wins).
//    The write data is still stored.
//  - Read: rs_data_j = regs[rs_addr_j], zero-extended nothing; full XLEN.
//  - BYPASS=1: if any we[i] targets rs_addr_j this cycle (not reg0 under ZERO_REG), rs_data_j = winning wb_data.
//    In that case rs_busy_j = 0 unless set_busy also targets rs_addr_j.
//  - BYPASS=0: reads and busy reflect only the state registered at the last edge.
//  - Out-of-range addresses are impossible: NREGS = 2**AW.
//  - No read latency. Write latency is 1 edge (0 effective when BYPASS=1).
// STRUCTURE
//  - Package regfile_pkg: default XLEN/NREGS constants, function rf_aw(n)=$clog2(n),
//    and the state enum {RF_CLEAR, RF_READY}.
//  - Sub-module regfile_clear_fsm: state register, clr_idx counter, ready and clear-write strobe.
//  - Top module: storage array, write-priority mux, scoreboard vector, and per-port read/bypass mux in a generate loop.
// TESTING
//  - Reset then idle: ready rises after exactly 32 edges. Every rs_data=0 and rs_busy=0 before and after.
//  - Write port0 r5=0xDEADBEEF, then read r5 on both ports next cycle -> 0xDEADBEEF, busy=0.
//  - Same edge, port0 r7=0x1111 and port1 r7=0x2222 -> r7 reads 0x2222.
//    With BYPASS=1 it reads 0x2222 combinationally in that cycle.
//  - set_busy r3 -> rs_busy=1. A later write r3=0x42 -> busy=0, data 0x42.
//    set_busy and write r3 in the same cycle -> busy stays 1.
//  - Write r0=0xFFFF_FFFF and set_busy r0 -> r0 reads 0, busy=0 (ZERO_REG=1).
//  - Assert reset at clr_idx=10 -> ready stays 0 and the clear restarts at index 0.
//    Write r9 during CLEAR is ignored, so r9 reads 0 after ready.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port scoreboarded register file.
// Holds the default geometry, the address-width helper and the clear/ready state type.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every register index once after reset, then holds READY.
// Supplies the clear index, the clear-write strobe and the ready flag to the file.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ready_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_idx_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    // State and clear-index registers; reset restarts the sweep from index 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next-state logic: advance the sweep and leave CLEAR after the last index
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            RF_CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RF_READY;
                end else begin
                    state_d = RF_CLEAR;
                end
            end
            RF_READY: begin
                state_d = RF_READY;
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // The array must stay untouched while reset is held, even in CLEAR
    assign ready_o   = (state_q == RF_READY);
    assign clr_we_o  = (state_q == RF_CLEAR) && !reset;
    assign clr_idx_o = clr_idx_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a per-register busy scoreboard and hardware clear.
// Asynchronous operand reads with optional same-cycle write forwarding.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NRD      = 2,
    parameter  int NWR      = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wb_addr,
    input  logic [NWR*XLEN-1:0] wb_data,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                set_busy,
    input  logic [AW-1:0]       set_addr
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    logic          ready_s;
    logic          clr_we_s;
    logic [AW-1:0] clr_idx_s;
    logic          wr_en_s;
    logic          set_ok_s;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (ZERO_REG == 0) || (a != '0);
    endfunction

    regfile_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk       (clk),
        .reset     (reset),
        .ready_o   (ready_s),
        .clr_we_o  (clr_we_s),
        .clr_idx_o (clr_idx_s)
    );

    assign ready    = ready_s;
    assign wr_en_s  = ready_s && !reset;
    assign set_ok_s = wr_en_s && set_busy && addr_ok(set_addr);

    // Array/scoreboard next state: clear sweep, then writes in port order, then issue marking
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (clr_we_s) begin
            regs_d[clr_idx_s] = '0;
            busy_d[clr_idx_s] = 1'b0;
        end else if (wr_en_s) begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && addr_ok(wb_addr[i*AW +: AW])) begin
                    regs_d[wb_addr[i*AW +: AW]] = wb_data[i*XLEN +: XLEN];
                    busy_d[wb_addr[i*AW +: AW]] = 1'b0;
                end else begin
                    busy_d = busy_d;
                end
            end
            // A newly issued producer outranks a retiring one on the same register
            if (set_ok_s) begin
                busy_d[set_addr] = 1'b1;
            end else begin
                busy_d = busy_d;
            end
        end else begin
            busy_d = busy_q;
        end
    end

    // Storage registers; reset gating is handled through the clear/write strobes
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   ra_s;
        logic            hit_s;
        logic [XLEN-1:0] byp_s;
        logic [XLEN-1:0] data_s;
        logic            busy_s;

        assign ra_s = rs_addr[j*AW +: AW];

        // Find the winning same-cycle write to this read address (highest port last)
        always_comb begin
            hit_s = 1'b0;
            byp_s = '0;
            for (int i = 0; i < NWR; i++) begin
                if (wr_en_s && we[i] && addr_ok(wb_addr[i*AW +: AW]) &&
                    (wb_addr[i*AW +: AW] == ra_s)) begin
                    hit_s = 1'b1;
                    byp_s = wb_data[i*XLEN +: XLEN];
                end else begin
                    hit_s = hit_s;
                end
            end
        end

        // Read mux: zero while clearing or for the hardwired zero register
        always_comb begin
            data_s = '0;
            busy_s = 1'b0;
            if (!ready_s || !addr_ok(ra_s)) begin
                data_s = '0;
                busy_s = 1'b0;
            end else if ((BYPASS != 0) && hit_s) begin
                data_s = byp_s;
                busy_s = set_ok_s && (set_addr == ra_s);
            end else begin
                data_s = regs_q[ra_s];
                busy_s = busy_q[ra_s];
            end
        end

        assign rs_data[j*XLEN +: XLEN] = data_s;
        assign rs_busy[j]              = busy_s;
    end

endmodule
